fifo_wr_arbiter: RTL and testbench

Single-clock write-side arbiter that shares the 16-bit write port of the team's FIFO (`din_a`/`wen_a`, `full` flag) between `NREQ` independent producers. Producers use a valid/ready handshake. The block grants the port to one producer at a time in round-robin order, for bursts of up to `BURST_MAX` words. It sits in the `clk_a` domain directly in front of the FIFO write side and keeps a running count of words written.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_picker.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// The width helper never returns less than 1, so a 1-bit field is still legal.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DW    = 16;
    localparam int DEFAULT_CNT_W = 32;

    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: the first asserted request at or above
// rr_ptr, wrapping modulo NREQ, wins.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   winner
);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [IW:0]       sum;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves one unassigned, which would infer a latch.
    always_comb begin
        doubled = {req_valid, req_valid} >> rr_ptr;
        rotated = doubled[NREQ-1:0];
        found   = |rotated;
        winner  = '0;
        sum     = '0;
        // Descending scan: the last hit written is the smallest offset from rr_ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = {1'b0, rr_ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                winner = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between NREQ valid/ready producers, granting
// round-robin bursts of up to BURST_MAX words and counting words written.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = DEFAULT_DW,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                   clk_a,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DW-1:0]     req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_full,
    output logic [DW-1:0]          din_a,
    output logic                   wen_a,
    output logic [clog2(NREQ)-1:0] grant_id,
    output logic                   busy,
    output logic [CNT_W-1:0]       total_cnt
);

    localparam int            GW         = clog2(NREQ);
    localparam int            BW         = clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    arb_state_e       state_q;
    logic [GW-1:0]    rr_ptr_q;
    logic [GW-1:0]    grant_id_q;
    logic [BW-1:0]    burst_cnt_q;
    logic [CNT_W-1:0] total_cnt_q;
    logic [CNT_W-1:0] total_cnt_d;
    logic [GW-1:0]    rr_ptr_d;

    logic          found;
    logic [GW-1:0] winner;
    logic          in_grant;
    logic          owner_valid;
    logic          accept;
    logic          burst_done;
    logic          release_grant;
    logic [DW-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (GW)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (found),
        .winner    (winner)
    );

    // The write path stays combinational so fifo_full gates the very edge it is seen on.
    always_comb begin
        in_grant      = (state_q == GRANT);
        owner_valid   = req_valid[grant_id_q];
        accept        = in_grant && owner_valid && !fifo_full;
        burst_done    = accept && (burst_cnt_q == BURST_LAST);
        release_grant = in_grant && (burst_done || !owner_valid);
        rr_ptr_d      = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + GW'(1);
        total_cnt_d   = total_cnt_q + CNT_W'(accept);

        req_ready = '0;
        if (in_grant) begin
            req_ready[grant_id_q] = !fifo_full;
        end
        din_a = in_grant ? data_arr[grant_id_q] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            total_cnt_q <= '0;
        end else begin
            total_cnt_q <= total_cnt_d;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_id_q <= winner;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        state_q     <= IDLE;
                        rr_ptr_q    <= rr_ptr_d;
                        burst_cnt_q <= '0;
                    end else if (accept) begin
                        burst_cnt_q <= burst_cnt_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wen_a     = accept;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == GRANT);
    assign total_cnt = total_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: the driver runs a transaction-level arbiter model and
// queues expectations; a negedge monitor pops and compares against the DUT.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int DW        = 16;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 32;
    localparam int GW        = clog2(NREQ);

    logic                 clk_a     = 1'b0;
    logic                 rst       = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_data  = '0;
    logic                 fifo_full = 1'b0;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        din_a;
    logic                 wen_a;
    logic [GW-1:0]        grant_id;
    logic                 busy;
    logic [CNT_W-1:0]     total_cnt;

    logic [NREQ-1:0]      n_req_ready;
    logic [DW-1:0]        n_din_a;
    logic                 n_wen_a;
    logic [GW-1:0]        n_grant_id;
    logic                 n_busy;
    logic [3:0]           n_total_cnt;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) u_dut (
        .clk_a     (clk_a),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .din_a     (din_a),
        .wen_a     (wen_a),
        .grant_id  (grant_id),
        .busy      (busy),
        .total_cnt (total_cnt)
    );

    // Narrow-counter twin on the same inputs, used only for counter wrap.
    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST_MAX), .CNT_W(4)) u_dut_narrow (
        .clk_a     (clk_a),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (n_req_ready),
        .fifo_full (fifo_full),
        .din_a     (n_din_a),
        .wen_a     (n_wen_a),
        .grant_id  (n_grant_id),
        .busy      (n_busy),
        .total_cnt (n_total_cnt)
    );

    always #5 clk_a = ~clk_a;

    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int               cyc;
        logic             busy;
        logic [NREQ-1:0]  ready;
        int               grant;
        logic [CNT_W-1:0] total;
        logic [3:0]       total4;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] cur_data [NREQ];
    logic [DW-1:0] dir_q[$];
    int            dir_id = -1;

    // Model: owner is -1 while idle; words counts accepts in the current burst.
    int               m_owner = -1;
    int               m_ptr   = 0;
    int               m_grant = 0;
    int               m_words = 0;
    logic [CNT_W-1:0] m_total = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic refill(input int i);
        if (i == dir_id && dir_q.size() > 0) cur_data[i] = dir_q.pop_front();
        else                                 cur_data[i] = DW'($urandom);
    endtask

    task automatic end_burst();
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_words = 0;
    endtask

    task automatic step(input logic [NREQ-1:0] v, input logic full, input logic r);
        st_t st;
        @(posedge clk_a);
        #1;
        rst       = r;
        fifo_full = full;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = cur_data[i];
        cyc++;

        st.cyc    = cyc;
        st.busy   = 1'b0;
        st.ready  = '0;
        st.grant  = m_grant;
        st.total  = m_total;
        st.total4 = m_total[3:0];

        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_grant = 0;
            m_words = 0;
            m_total = '0;
            st.grant  = 0;
            st.total  = '0;
            st.total4 = '0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx = (m_ptr + k) % NREQ;
                if (m_owner < 0 && v[idx]) m_owner = idx;
            end
            if (m_owner >= 0) begin
                m_grant = m_owner;
                m_words = 0;
            end
        end else begin
            st.busy  = 1'b1;
            st.grant = m_owner;
            if (!full) st.ready[m_owner] = 1'b1;
            if (v[m_owner] && !full) begin
                wr_q.push_back('{cyc, m_owner, cur_data[m_owner]});
                m_total = m_total + 1;
                m_words++;
                refill(m_owner);
                if (m_words == BURST_MAX) end_burst();
            end else if (!v[m_owner]) begin
                end_burst();
            end
        end
        st_q.push_back(st);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0);
    endtask

    // Monitor
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk_a);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("busy", busy, s.busy);
                check("req_ready", req_ready, s.ready);
                check("grant_id", grant_id, s.grant);
                check("total_cnt", total_cnt, s.total);
                check("total_cnt_w4", n_total_cnt, s.total4);
            end
            check("wen_while_full", wen_a & fifo_full, 0);
            if (wen_a) begin
                if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                    w = wr_q.pop_front();
                    check("din_a", din_a, w.data);
                    check("write_owner", grant_id, w.id);
                end else begin
                    check("unexpected_wen_a", wen_a, 0);
                end
            end else if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                w = wr_q.pop_front();
                check("missing_wen_a", wen_a, 1);
            end
            if (!wen_a) check("din_a_idle", din_a, busy ? din_a : '0);
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) refill(i);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) step(NREQ'($urandom), 1'($urandom), 1'b1);

        // Requester 2 sends three known words then drops valid
        dir_id = 2;
        dir_q.push_back(16'h1111);
        dir_q.push_back(16'h2222);
        dir_q.push_back(16'h3333);
        refill(2);
        for (int i = 0; i < 4; i++) step(4'b0100, 1'b0, 1'b0);
        idle_steps(2);
        dir_id = -1;

        // All requesters continuously valid from a clean pointer
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 36; i++) step(4'b1111, 1'b0, 1'b0);
        idle_steps(2);

        // Requester 1 stalled by a full FIFO after word 3
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 1'b0);
        idle_steps(2);

        // Owner drops valid while the FIFO goes full
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        idle_steps(1);

        // Reset during word 4 of requester 0, then requester 3 alone
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b0, 1'b0);
        idle_steps(2);

        // Seventeen words with random back-pressure wrap the 4-bit counter
        step('0, 1'b0, 1'b1);
        for (int i = 0; i < 300 && m_total < 17; i++)
            step(4'b0010, ($urandom_range(0, 3) == 0), 1'b0);
        idle_steps(2);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [NREQ-1:0] v;
            for (int j = 0; j < NREQ; j++) v[j] = ($urandom_range(0, 3) != 0);
            step(v, ($urandom_range(0, 4) == 0), ($urandom_range(0, 599) == 0));
        end
        idle_steps(3);

        @(negedge clk_a);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
